alu_arbiter: RTL

Shares the single 64-bit ALU of the execute datapath between two requesters: requester 0 (integer execute) and requester 1 (branch/address helper). Each requester uses a valid/ready handshake. The block grants round-robin, registers the operands that drive the ALU, captures `out` and `Z`, and returns them over a per-requester response handshake. Opcodes outside the ALU's supported set are rejected with an error response and never reach the ALU.

---
 rtl/alu_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin share of one W-bit ALU between two valid/ready requesters; legal op responds at T+2, illegal at T+1.
// Response is held until the owner's rready; no new request is accepted while busy.
module alu_arbiter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         r0_valid,
    input  logic         r1_valid,
    output logic         r0_ready,
    output logic         r1_ready,
    input  logic [W-1:0] r0_a,
    input  logic [W-1:0] r1_a,
    input  logic [W-1:0] r0_b,
    input  logic [W-1:0] r1_b,
    input  logic [3:0]   r0_op,
    input  logic [3:0]   r1_op,
    output logic         r0_rvalid,
    output logic         r1_rvalid,
    input  logic         r0_rready,
    input  logic         r1_rready,
    output logic [W-1:0] rsp_out,
    output logic         rsp_z,
    output logic         rsp_err,
    output logic [W-1:0] alu_in1,
    output logic [W-1:0] alu_in2,
    output logic [3:0]   alu_op,
    input  logic [W-1:0] alu_out,
    input  logic         alu_z,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_q, state_d;
    logic           prio_q, prio_d;
    logic           owner_q, owner_d;
    logic [W-1:0]   in1_q, in1_d, in2_q, in2_d;
    logic [3:0]     op_q, op_d;
    logic [W-1:0]   out_q, out_d;
    logic           z_q, z_d, err_q, err_d;

    logic           accept, gnt_id, sel_legal;
    logic [W-1:0]   sel_a, sel_b;
    logic [3:0]     sel_op;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: op_legal = 1'b1;
            default:                                              op_legal = 1'b0;
        endcase
    endfunction

    // prio breaks the tie only when both requesters are valid
    assign r0_ready  = (state_q == IDLE) && r0_valid && (!r1_valid || !prio_q);
    assign r1_ready  = (state_q == IDLE) && r1_valid && (!r0_valid ||  prio_q);
    assign accept    = r0_ready || r1_ready;
    assign gnt_id    = r1_ready;
    assign sel_a     = gnt_id ? r1_a  : r0_a;
    assign sel_b     = gnt_id ? r1_b  : r0_b;
    assign sel_op    = gnt_id ? r1_op : r0_op;
    assign sel_legal = op_legal(sel_op);

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        op_d    = op_q;
        out_d   = out_q;
        z_d     = z_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    prio_d  = ~gnt_id;
                    owner_d = gnt_id;
                    if (sel_legal) begin
                        in1_d   = sel_a;
                        in2_d   = sel_b;
                        op_d    = sel_op;
                        state_d = EXEC;
                    end else begin
                        // illegal op never touches the ALU registers
                        out_d   = '0;
                        z_d     = 1'b0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            EXEC: begin
                out_d   = alu_out;
                z_d     = alu_z;
                err_d   = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                if (owner_q ? r1_rready : r0_rready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            in1_q   <= '0;
            in2_q   <= '0;
            op_q    <= 4'b0000;
            out_q   <= '0;
            z_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            op_q    <= op_d;
            out_q   <= out_d;
            z_q     <= z_d;
            err_q   <= err_d;
        end
    end

    assign r0_rvalid = (state_q == RESP) && !owner_q;
    assign r1_rvalid = (state_q == RESP) &&  owner_q;
    assign rsp_out   = out_q;
    assign rsp_z     = z_q;
    assign rsp_err   = err_q;
    assign alu_in1   = in1_q;
    assign alu_in2   = in2_q;
    assign alu_op    = op_q;
    assign busy      = (state_q != IDLE);

endmodule
